// File: rtl/xif_coproc_alu_if.sv
// ----------------------------------------------------------------------------
// xif_coproc_alu_if
// Bundle of the eXtension-interface signals exchanged between the srv32 core
// and the xif_coproc_alu coprocessor (issue, register, commit and result
// channels).
//
// Modports:
//   master : core side; drives issue/register/commit requests and result_ready
//   slave  : coprocessor side; drives the issue response, register_ready and
//            the result channel
//
// Signals:
//   issue_valid/ready, issue_instr[31:0], issue_id, issue_accept,
//   issue_writeback
//   register_valid/ready, register_id, register_rs1/rs2[31:0],
//   register_rs_valid[1:0]
//   commit_valid, commit_id, commit_kill
//   result_valid/ready, result_id, result_data[31:0], result_rd[4:0],
//   result_we, result_exc
// ----------------------------------------------------------------------------
interface xif_coproc_alu_if #(
    parameter int X_ID_WIDTH = 4
);
    // Issue channel
    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_instr;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic                  issue_accept;
    logic                  issue_writeback;

    // Register (operand) channel
    logic                  register_valid;
    logic                  register_ready;
    logic [X_ID_WIDTH-1:0] register_id;
    logic [31:0]           register_rs1;
    logic [31:0]           register_rs2;
    logic [1:0]            register_rs_valid;

    // Commit channel (no ready: the coprocessor must always observe it)
    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;

    // Result channel
    logic                  result_valid;
    logic                  result_ready;
    logic [X_ID_WIDTH-1:0] result_id;
    logic [31:0]           result_data;
    logic [4:0]            result_rd;
    logic                  result_we;
    logic                  result_exc;

    modport master (
        output issue_valid, issue_instr, issue_id,
        input  issue_ready, issue_accept, issue_writeback,
        output register_valid, register_id, register_rs1, register_rs2,
               register_rs_valid,
        input  register_ready,
        output commit_valid, commit_id, commit_kill,
        input  result_valid, result_id, result_data, result_rd, result_we,
               result_exc,
        output result_ready
    );

    modport slave (
        input  issue_valid, issue_instr, issue_id,
        output issue_ready, issue_accept, issue_writeback,
        input  register_valid, register_id, register_rs1, register_rs2,
               register_rs_valid,
        output register_ready,
        input  commit_valid, commit_id, commit_kill,
        output result_valid, result_id, result_data, result_rd, result_we,
               result_exc,
        input  result_ready
    );
endinterface

// File: rtl/xif_coproc_alu.sv
// ----------------------------------------------------------------------------
// xif_coproc_alu
// Coprocessor responder for custom-0 instructions offloaded over the
// eXtension interface. One instruction is in flight at a time: it is issued,
// waits for its operands and commit decision, executes (MINU, MAXU, ABSDIFF
// in one step, MULLO as a 32-cycle shift-and-add) and is returned on the
// result channel.
//
// Ports:
//   clk_i    : clock
//   resetb_i : asynchronous active-low reset; drops any in-flight instruction
//   xif      : eXtension interface, slave side (see xif_coproc_alu_if)
// ----------------------------------------------------------------------------
module xif_coproc_alu #(
    parameter int X_ID_WIDTH = 4
) (
    input  logic            clk_i,
    input  logic            resetb_i,
    xif_coproc_alu_if.slave xif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
    localparam logic [1:0] OP_MINU        = 2'd0;
    localparam logic [1:0] OP_MAXU        = 2'd1;
    localparam logic [1:0] OP_ABSDIFF     = 2'd2;
    localparam logic [1:0] OP_MULLO       = 2'd3;

    state_e                state_q, state_d;
    logic [X_ID_WIDTH-1:0] id_q, id_d;
    logic [1:0]            op_q, op_d;
    logic [4:0]            rd_q, rd_d;
    logic                  writeback_q, writeback_d;
    logic                  ops_q, ops_d;
    logic                  committed_q, committed_d;
    logic [31:0]           rs1_q, rs1_d;
    logic [31:0]           rs2_q, rs2_d;
    logic [31:0]           acc_q, acc_d;
    logic [31:0]           mcand_q, mcand_d;
    logic [31:0]           mplier_q, mplier_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [31:0]           resultData_q, resultData_d;

    logic [6:0]            instrOpcode;
    logic [4:0]            instrRd;
    logic [2:0]            instrFunct3;
    logic [6:0]            instrFunct7;
    logic                  decodeOk;
    logic                  issueFire;
    logic                  opCapture;
    logic                  commitHit;
    logic                  commitNow;
    logic [31:0]           opA;
    logic [31:0]           opB;
    logic [31:0]           accSum;
    logic                  unusedInstrBits;

    // One-step unsigned operations; MULLO is handled by the EXEC loop.
    function automatic logic [31:0] aluSimple(input logic [1:0]  op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] res;
        res = 32'd0;
        case (op)
            OP_MINU:    res = (a < b) ? a : b;
            OP_MAXU:    res = (a > b) ? a : b;
            OP_ABSDIFF: res = (a > b) ? (a - b) : (b - a);
            default:    res = 32'd0;
        endcase
        return res;
    endfunction

    // Instruction field extraction; the rs1/rs2 register specifiers are not
    // needed because the core delivers the operand values separately.
    assign instrOpcode     = xif.issue_instr[6:0];
    assign instrRd         = xif.issue_instr[11:7];
    assign instrFunct3     = xif.issue_instr[14:12];
    assign instrFunct7     = xif.issue_instr[31:25];
    assign unusedInstrBits = ^xif.issue_instr[24:15];

    // funct3 values 0..3 are the only implemented operations.
    assign decodeOk = (instrOpcode == OPCODE_CUSTOM0) &&
                      (instrFunct7 == 7'd0) && !instrFunct3[2];

    // Zero-latency issue response, valid whenever an instruction is offered.
    assign xif.issue_accept    = xif.issue_valid & decodeOk;
    assign xif.issue_writeback = xif.issue_valid & decodeOk & (instrRd != 5'd0);
    assign xif.issue_ready     = (state_q == IDLE);
    assign issueFire           = xif.issue_valid & xif.issue_ready & decodeOk;

    assign xif.register_ready = (state_q == WAIT) && !ops_q;

    // Result fields come straight from registers so they hold still under
    // backpressure and read as zero out of reset.
    assign xif.result_valid = (state_q == RESP);
    assign xif.result_id    = id_q;
    assign xif.result_rd    = rd_q;
    assign xif.result_we    = writeback_q;
    assign xif.result_data  = resultData_q;
    assign xif.result_exc   = 1'b0;

    // State and datapath registers. Reset clears everything, which both
    // abandons an in-flight instruction and gives the zero result outputs.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q      <= IDLE;
            id_q         <= '0;
            op_q         <= 2'd0;
            rd_q         <= 5'd0;
            writeback_q  <= 1'b0;
            ops_q        <= 1'b0;
            committed_q  <= 1'b0;
            rs1_q        <= 32'd0;
            rs2_q        <= 32'd0;
            acc_q        <= 32'd0;
            mcand_q      <= 32'd0;
            mplier_q     <= 32'd0;
            cnt_q        <= 5'd0;
            resultData_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            writeback_q  <= writeback_d;
            ops_q        <= ops_d;
            committed_q  <= committed_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            resultData_q <= resultData_d;
        end
    end

    // Next-state logic. In WAIT the operand capture and the commit are folded
    // in with the current flags so that an instruction whose last missing
    // piece arrives this cycle starts executing immediately. A kill takes
    // priority over an operand capture in the same cycle.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        op_d         = op_q;
        rd_d         = rd_q;
        writeback_d  = writeback_q;
        ops_d        = ops_q;
        committed_d  = committed_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        resultData_d = resultData_q;
        opCapture    = 1'b0;
        commitHit    = 1'b0;
        commitNow    = 1'b0;
        opA          = rs1_q;
        opB          = rs2_q;
        accSum       = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

        case (state_q)
            IDLE: begin
                if (issueFire) begin
                    id_d        = xif.issue_id;
                    op_d        = instrFunct3[1:0];
                    rd_d        = instrRd;
                    writeback_d = (instrRd != 5'd0);
                    ops_d       = 1'b0;
                    committed_d = 1'b0;
                    state_d     = WAIT;
                end
            end

            WAIT: begin
                opCapture = xif.register_valid && !ops_q &&
                            (xif.register_id == id_q) &&
                            (xif.register_rs_valid == 2'b11);
                commitHit = xif.commit_valid && (xif.commit_id == id_q);

                if (opCapture) begin
                    rs1_d = xif.register_rs1;
                    rs2_d = xif.register_rs2;
                    ops_d = 1'b1;
                    opA   = xif.register_rs1;
                    opB   = xif.register_rs2;
                end

                if (commitHit && xif.commit_kill) begin
                    state_d = IDLE;
                end else begin
                    commitNow = committed_q || commitHit;
                    if (commitHit) begin
                        committed_d = 1'b1;
                    end
                    if ((ops_q || opCapture) && commitNow) begin
                        if (op_q == OP_MULLO) begin
                            acc_d    = 32'd0;
                            mcand_d  = opA;
                            mplier_d = opB;
                            cnt_d    = 5'd0;
                            state_d  = EXEC;
                        end else begin
                            resultData_d = aluSimple(op_q, opA, opB);
                            state_d      = RESP;
                        end
                    end
                end
            end

            EXEC: begin
                acc_d    = accSum;
                mcand_d  = {mcand_q[30:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    resultData_d = accSum;
                    state_d      = RESP;
                end
            end

            RESP: begin
                if (xif.result_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xif_coproc_alu.sv
// ----------------------------------------------------------------------------
// tb_xif_coproc_alu
// Self-checking bench for xif_coproc_alu. Drives directed and random offload
// transactions and compares the coprocessor's responses with an arithmetic
// reference of the four operations and their expected cycle timing.
// ----------------------------------------------------------------------------
module tb_xif_coproc_alu;

    localparam int X_ID_WIDTH = 4;

    logic clk = 1'b0;
    logic resetb;
    int   vectors = 0;
    int   miscompares = 0;

    xif_coproc_alu_if #(.X_ID_WIDTH(X_ID_WIDTH)) xif ();

    xif_coproc_alu #(.X_ID_WIDTH(X_ID_WIDTH)) dut (
        .clk_i    (clk),
        .resetb_i (resetb),
        .xif      (xif)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference arithmetic for the four custom-0 operations.
    function automatic logic [31:0] refAlu(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0:    r = (a < b) ? a : b;
            3'd1:    r = (a > b) ? a : b;
            3'd2:    r = (a > b) ? a - b : b - a;
            default: r = a * b;
        endcase
        return r;
    endfunction

    task automatic idleInputs();
        xif.issue_valid       = 1'b0;
        xif.issue_instr       = 32'd0;
        xif.issue_id          = '0;
        xif.register_valid    = 1'b0;
        xif.register_id       = '0;
        xif.register_rs1      = 32'd0;
        xif.register_rs2      = 32'd0;
        xif.register_rs_valid = 2'b00;
        xif.commit_valid      = 1'b0;
        xif.commit_id         = '0;
        xif.commit_kill       = 1'b0;
        xif.result_ready      = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        resetb = 1'b0;
        idleInputs();
        @(negedge clk);
        resetb = 1'b1;
    endtask

    // Checks every output against its post-reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_issue_ready"}, 32'(xif.issue_ready), 32'd1);
        checkOutput({tag, "_register_ready"}, 32'(xif.register_ready), 32'd0);
        checkOutput({tag, "_result_valid"}, 32'(xif.result_valid), 32'd0);
        checkOutput({tag, "_result_id"}, 32'(xif.result_id), 32'd0);
        checkOutput({tag, "_result_data"}, xif.result_data, 32'd0);
        checkOutput({tag, "_result_rd"}, 32'(xif.result_rd), 32'd0);
        checkOutput({tag, "_result_we"}, 32'(xif.result_we), 32'd0);
        checkOutput({tag, "_result_exc"}, 32'(xif.result_exc), 32'd0);
    endtask

    // Offers one instruction in the current (IDLE) cycle and checks the
    // combinational issue response against the decode rules.
    task automatic issueInstr(input logic [3:0] id, input logic [6:0] opcode,
                              input logic [6:0] funct7, input logic [2:0] funct3,
                              input logic [4:0] rd, output logic accepted);
        logic [9:0] regFields;
        logic       expAcc;
        @(negedge clk);
        idleInputs();
        regFields       = 10'($urandom);
        xif.issue_valid = 1'b1;
        xif.issue_id    = id;
        xif.issue_instr = {funct7, regFields, funct3, rd, opcode};
        #1;
        expAcc = (opcode == 7'b0001011) && (funct7 == 7'd0) && (funct3 < 3'd4);
        checkOutput("issue_ready", 32'(xif.issue_ready), 32'd1);
        checkOutput("issue_accept", 32'(xif.issue_accept), 32'(expAcc));
        checkOutput("issue_writeback", 32'(xif.issue_writeback), 32'(expAcc && (rd != 5'd0)));
        accepted = expAcc;
    endtask

    // Full transaction: issue in cycle 0, commit in cycle commitAt, operands
    // in cycle opsAt (with off-id / partially valid noise in other cycles),
    // then the result is held off by bp cycles of backpressure.
    task automatic applyStimulus(input logic [3:0] id, input logic [2:0] f3,
                                 input logic [4:0] rd, input logic [31:0] a,
                                 input logic [31:0] b, input int commitAt,
                                 input int opsAt, input int bp);
        logic        acc;
        logic [31:0] expData;
        int          last;
        int          cyc;
        int          expLat;
        issueInstr(id, 7'b0001011, 7'd0, f3, rd, acc);
        expData = refAlu(f3, a, b);
        last    = (commitAt > opsAt) ? commitAt : opsAt;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            idleInputs();
            if (c == opsAt) begin
                xif.register_valid    = 1'b1;
                xif.register_id       = id;
                xif.register_rs1      = a;
                xif.register_rs2      = b;
                xif.register_rs_valid = 2'b11;
            end else if ($urandom_range(1, 0) == 1) begin
                xif.register_valid = 1'b1;
                xif.register_rs1   = $urandom;
                xif.register_rs2   = $urandom;
                if ($urandom_range(1, 0) == 1) begin
                    xif.register_id       = id ^ 4'($urandom_range(15, 1));
                    xif.register_rs_valid = 2'b11;
                end else begin
                    xif.register_id       = id;
                    xif.register_rs_valid = 2'($urandom_range(2, 0));
                end
            end
            if (c == commitAt) begin
                xif.commit_valid = 1'b1;
                xif.commit_id    = id;
                xif.commit_kill  = 1'b0;
            end else if ($urandom_range(1, 0) == 1) begin
                xif.commit_valid = 1'b1;
                xif.commit_id    = id ^ 4'($urandom_range(15, 1));
                xif.commit_kill  = 1'($urandom_range(1, 0));
            end
            #1;
            checkOutput("issue_ready_wait", 32'(xif.issue_ready), 32'd0);
            checkOutput("register_ready", 32'(xif.register_ready), 32'(c <= opsAt));
        end

        @(negedge clk);
        idleInputs();
        cyc    = last + 1;
        expLat = last + 1 + ((f3 == 3'd3) ? 32 : 0);
        while (!xif.result_valid && cyc < last + 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("result_latency", 32'(cyc), 32'(expLat));
        if (!xif.result_valid) begin
            applyReset();
            return;
        end

        for (int k = 0; k <= bp; k++) begin
            checkOutput("result_valid", 32'(xif.result_valid), 32'd1);
            checkOutput("result_data", xif.result_data, expData);
            checkOutput("result_id", 32'(xif.result_id), 32'(id));
            checkOutput("result_rd", 32'(xif.result_rd), 32'(rd));
            checkOutput("result_we", 32'(xif.result_we), 32'(rd != 5'd0));
            checkOutput("result_exc", 32'(xif.result_exc), 32'd0);
            checkOutput("issue_ready_resp", 32'(xif.issue_ready), 32'd0);
            if (k < bp) begin
                @(negedge clk);
            end
        end
        xif.result_ready = 1'b1;
        @(negedge clk);
        xif.result_ready = 1'b0;
        #1;
        checkOutput("result_valid_after", 32'(xif.result_valid), 32'd0);
        checkOutput("issue_ready_after", 32'(xif.issue_ready), 32'd1);
    endtask

    // Kill in WAIT: optionally after operands arrived; no result may appear.
    task automatic applyKill(input logic [3:0] id, input logic [2:0] f3, input int killAt,
                             input logic opsFirst);
        logic acc;
        issueInstr(id, 7'b0001011, 7'd0, f3, 5'd7, acc);
        for (int c = 1; c <= killAt; c++) begin
            @(negedge clk);
            idleInputs();
            if (opsFirst && c == 1) begin
                xif.register_valid    = 1'b1;
                xif.register_id       = id;
                xif.register_rs1      = $urandom;
                xif.register_rs2      = $urandom;
                xif.register_rs_valid = 2'b11;
            end
            if (c == killAt) begin
                xif.commit_valid = 1'b1;
                xif.commit_id    = id;
                xif.commit_kill  = 1'b1;
            end
        end
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("kill_issue_ready", 32'(xif.issue_ready), 32'd1);
        checkOutput("kill_result_valid", 32'(xif.result_valid), 32'd0);
        @(negedge clk);
        checkOutput("kill_result_valid_later", 32'(xif.result_valid), 32'd0);
    endtask

    // Rejected instruction: no response and the FSM remains idle.
    task automatic applyReject(input logic [6:0] opcode, input logic [2:0] f3);
        logic acc;
        issueInstr(4'd9, opcode, 7'd0, f3, 5'd3, acc);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("reject_issue_ready", 32'(xif.issue_ready), 32'd1);
        checkOutput("reject_register_ready", 32'(xif.register_ready), 32'd0);
    endtask

    // Reset asserted in the tenth EXEC cycle of a MULLO.
    task automatic applyMidReset();
        logic acc;
        issueInstr(4'd6, 7'b0001011, 7'd0, 3'd3, 5'd12, acc);
        @(negedge clk);
        idleInputs();
        xif.register_valid    = 1'b1;
        xif.register_id       = 4'd6;
        xif.register_rs1      = 32'h0000_0123;
        xif.register_rs2      = 32'h0000_0456;
        xif.register_rs_valid = 2'b11;
        xif.commit_valid      = 1'b1;
        xif.commit_id         = 4'd6;
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            idleInputs();
        end
        resetb = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        resetb = 1'b1;
    endtask

    // Watchdog so a hung bench still ends with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, then random traffic.
    initial begin
        logic [31:0] edges [4];
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        edges[0] = 32'd0;
        edges[1] = 32'hFFFF_FFFF;
        edges[2] = 32'd1;
        edges[3] = 32'h8000_0000;

        resetb = 1'b0;
        idleInputs();
        @(negedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        resetb = 1'b1;

        applyStimulus(4'd3, 3'd2, 5'd5, 32'd10, 32'd25, 1, 1, 0);
        applyStimulus(4'd1, 3'd3, 5'd9, 32'hFFFF_FFFF, 32'd3, 1, 1, 0);
        applyStimulus(4'd2, 3'd3, 5'd10, 32'h0000_1234, 32'h0000_5678, 1, 1, 1);
        applyStimulus(4'd4, 3'd1, 5'd11, 32'd7, 32'd9, 1, 4, 0);
        applyKill(4'd5, 3'd0, 2, 1'b0);
        applyKill(4'd8, 3'd3, 1, 1'b1);
        applyReject(7'b0110011, 3'd0);
        applyReject(7'b0001011, 3'd5);
        applyStimulus(4'd7, 3'd0, 5'd0, 32'd100, 32'd50, 2, 1, 0);
        applyStimulus(4'd12, 3'd2, 5'd31, 32'd3, 32'd3, 1, 2, 5);
        applyMidReset();
        applyStimulus(4'd0, 3'd0, 5'd4, 32'd4, 32'd2, 1, 1, 0);

        for (int i = 0; i < 40; i++) begin
            a  = ($urandom_range(3, 0) == 0) ? edges[$urandom_range(3, 0)] : $urandom;
            b  = ($urandom_range(3, 0) == 0) ? edges[$urandom_range(3, 0)] : $urandom;
            rd = ($urandom_range(5, 0) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(7, 0) == 0) begin
                applyKill(4'($urandom), 3'($urandom_range(3, 0)), $urandom_range(3, 1),
                          1'($urandom_range(1, 0)));
            end else begin
                applyStimulus(4'($urandom), 3'($urandom_range(3, 0)), rd, a, b,
                              $urandom_range(4, 1), $urandom_range(4, 1),
                              $urandom_range(3, 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
